// File: rtl/pulse_seq_pkg.sv
// Shared encodings and default widths for the pulse sequencer.
package pulse_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_PULSE = PULSE,
    ST_GAP   = GAP,
    ST_DONE  = DONE
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, modulo N. Combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_next,
  output logic          valid
);

  // scan N positions starting at ptr, keep the first hit
  always_comb begin
    int idx;
    grant_next = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!valid && req[idx]) begin
        grant_next[idx] = 1'b1;
        valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Shared single-cycle pulse generator: round-robin grant, then a train of
// count pulses separated by a captured gap. All outputs are registered.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_count,
  input  logic [GAP_W-1:0]       gap_cycles,
  output logic                   pulse_out,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [N_REQ-1:0]       done
);

  localparam int PW = $clog2(N_REQ);

  state_t             state, state_nx;
  logic [PW-1:0]      ptr, owner, owner_nx, owner_inc, arb_idx;
  logic [N_REQ-1:0]   arb_gnt, oh_nx;
  logic               arb_vld, abort;
  logic [CNT_W-1:0]   rem, cnt_sel;
  logic [GAP_W-1:0]   gap_val, gap_left;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req        (req),
    .ptr        (ptr),
    .grant_next (arb_gnt),
    .valid      (arb_vld)
  );

  // one-hot winner to index, plus the values derived from it
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_gnt[i]) arb_idx = PW'(i);
    cnt_sel   = req_count[int'(arb_idx)*CNT_W +: CNT_W];
    owner_nx  = (state == ST_IDLE) ? arb_idx : owner;
    oh_nx     = N_REQ'(1) << owner_nx;
    owner_inc = (owner == PW'(N_REQ-1)) ? '0 : owner + 1'b1;
    abort     = ((state == ST_PULSE) || (state == ST_GAP)) && !req[owner];
  end

  // next-state logic; owner dropping req mid-train aborts straight to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arb_vld) state_nx = (cnt_sel != '0) ? ST_PULSE : ST_DONE;
      ST_PULSE: state_nx = abort ? ST_IDLE : ST_GAP;
      ST_GAP: begin
        if (abort)                 state_nx = ST_IDLE;
        else if (gap_left == GAP_W'(1))
          state_nx = (rem != '0) ? ST_PULSE : ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // state, counters, pointer and output registers (outputs decode next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      rem       <= '0;
      gap_val   <= '0;
      gap_left  <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      grant     <= '0;
      done      <= '0;
    end else begin
      state     <= state_nx;
      pulse_out <= (state_nx == ST_PULSE);
      busy      <= (state_nx != ST_IDLE);
      grant     <= (state_nx != ST_IDLE) ? oh_nx : '0;
      done      <= (state_nx == ST_DONE) ? oh_nx : '0;
      case (state)
        ST_IDLE: if (arb_vld) begin
          owner   <= arb_idx;
          rem     <= cnt_sel;
          gap_val <= (gap_cycles == '0) ? GAP_W'(1) : gap_cycles;
        end
        ST_PULSE: begin
          rem      <= rem - 1'b1;
          gap_left <= gap_val;
        end
        ST_GAP:   gap_left <= gap_left - 1'b1;
        default: ;
      endcase
      if ((state == ST_DONE) || abort) ptr <= owner_inc;
    end
  end

endmodule
